// File: rtl/i2c_oled_target.sv
// Write-only I2C target modelling the SSD1306 OLED end of the bus.
// Decodes address, control byte and payload; strobes each payload byte out.
module i2c_oled_target #(
  parameter logic [6:0] ADDR7  = 7'h3D,
  parameter bit         ACK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       byte_is_data,
  output logic       busy,
  output logic       addr_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    CTRL    = 3'd2,
    PAYLOAD = 3'd3,
    IGNORE  = 3'd4
  } state_t;

  state_t      state_r;
  logic [1:0]  scl_sync_r;
  logic [1:0]  sda_sync_r;
  logic        scl_hist_r;
  logic        sda_hist_r;
  logic [6:0]  shift_r;
  logic [3:0]  bit_cnt_r;
  logic        in_ack_r;
  logic        ack_r;
  logic        co_r;
  logic        dc_r;

  logic        scl_s;
  logic        sda_s;
  logic        scl_rise_s;
  logic        scl_fall_s;
  logic        start_s;
  logic        stop_s;
  logic        active_s;
  logic [7:0]  byte_s;

  // Two-flop synchronisers plus one history stage for edge detection
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
      scl_hist_r <= 1'b1;
      sda_hist_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[0], scl_in};
      sda_sync_r <= {sda_sync_r[0], sda_in};
      scl_hist_r <= scl_sync_r[1];
      sda_hist_r <= sda_sync_r[1];
    end
  end

  // Bus conditions; START/STOP only need SCL high now so STOP beats a coincident SCL edge
  always_comb begin
    scl_s      = scl_sync_r[1];
    sda_s      = sda_sync_r[1];
    scl_rise_s = scl_s & ~scl_hist_r;
    scl_fall_s = ~scl_s & scl_hist_r;
    start_s    = scl_s & sda_hist_r & ~sda_s;
    stop_s     = scl_s & ~sda_hist_r & sda_s;
    active_s   = (state_r == ADDR) || (state_r == CTRL) || (state_r == PAYLOAD);
    byte_s     = {shift_r, sda_s};
  end

  // Protocol FSM: bit shifting, byte decode, ACK drive and output strobes
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      shift_r      <= 7'd0;
      bit_cnt_r    <= 4'd0;
      in_ack_r     <= 1'b0;
      ack_r        <= 1'b0;
      co_r         <= 1'b0;
      dc_r         <= 1'b0;
      sda_oe       <= 1'b0;
      byte_out     <= 8'd0;
      byte_valid   <= 1'b0;
      byte_is_data <= 1'b0;
      busy         <= 1'b0;
      addr_err     <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      addr_err   <= 1'b0;
      if (stop_s) begin
        state_r   <= IDLE;
        busy      <= 1'b0;
        sda_oe    <= 1'b0;
        bit_cnt_r <= 4'd0;
        in_ack_r  <= 1'b0;
        ack_r     <= 1'b0;
      end else if (start_s) begin
        state_r   <= ADDR;
        sda_oe    <= 1'b0;
        bit_cnt_r <= 4'd0;
        in_ack_r  <= 1'b0;
        ack_r     <= 1'b0;
      end else if (scl_rise_s && active_s && (bit_cnt_r < 4'd8)) begin
        shift_r   <= byte_s[6:0];
        bit_cnt_r <= bit_cnt_r + 4'd1;
        if (bit_cnt_r == 4'd7) begin
          // The state advances at the 8th bit; the ACK clock that follows is never shifted
          case (state_r)
            ADDR: begin
              if ((byte_s[7:1] == ADDR7) && !byte_s[0]) begin
                busy    <= 1'b1;
                ack_r   <= 1'b1;
                state_r <= CTRL;
              end else begin
                busy     <= 1'b0;
                ack_r    <= 1'b0;
                addr_err <= 1'b1;
                state_r  <= IGNORE;
              end
            end
            CTRL: begin
              co_r    <= byte_s[7];
              dc_r    <= byte_s[6];
              ack_r   <= 1'b1;
              state_r <= PAYLOAD;
            end
            PAYLOAD: begin
              byte_out     <= byte_s;
              byte_is_data <= dc_r;
              byte_valid   <= 1'b1;
              ack_r        <= 1'b1;
              state_r      <= co_r ? CTRL : PAYLOAD;
            end
            default: begin
              ack_r   <= 1'b0;
              state_r <= IGNORE;
            end
          endcase
        end
      end else if (scl_fall_s && active_s && (bit_cnt_r == 4'd8)) begin
        if (!in_ack_r) begin
          in_ack_r <= 1'b1;
          sda_oe   <= ack_r & ACK_EN;
        end else begin
          in_ack_r  <= 1'b0;
          sda_oe    <= 1'b0;
          ack_r     <= 1'b0;
          bit_cnt_r <= 4'd0;
        end
      end else begin
        shift_r <= shift_r;
      end
    end
  end

endmodule
